alu_share_arbiter: RTL and testbench

- Shares the single 8-bit combinational ALU (`alv`: a, b, s → r) between N_REQ requesters.
- Each requester issues one operation {a, b, s} over a valid/ready handshake and receives its 8-bit result on a private valid/ready response channel.
- Round-robin arbitration; one operation in flight at a time.
- Sits between the ALU and the requesting sequencers/bus masters.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_share_arbiter_if.sv | 38 +++
 rtl/alv.sv | 27 ++
 rtl/rr_pick.sv | 33 +++
 rtl/alu_share_arbiter.sv | 99 +++++++++
 tb/tb_alu_share_arbiter.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU-sharing arbiter slice.
// Opcode map and FSM encodings used by the arbiter, the ALU and the bench.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-side bundle of the shared-ALU arbiter.
// master = requesters plus ALU, slave = arbiter.
interface alu_share_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 8
);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ*3-1:0] req_s;

  logic [W-1:0]       alu_a;
  logic [W-1:0]       alu_b;
  logic [2:0]         alu_s;
  logic [W-1:0]       alu_r;

  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [W-1:0]       rsp_data;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, req_s,
    output rsp_ready, alu_r,
    input  req_ready, alu_a, alu_b, alu_s,
    input  rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_s,
    input  rsp_ready, alu_r,
    output req_ready, alu_a, alu_b, alu_s,
    output rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/alv.sv
// 8-bit combinational ALU shared by the arbiter's requesters.
// Shifts move by one bit position.
module alv
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       s,
  output logic [ALU_W-1:0] r
);

  always_comb begin
    r = '0;
    unique case (s)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOTA: r = ~a;
      OP_SHL:  r = a << 1;
      OP_SHR:  r = a >> 1;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or
// after ptr_i, ascending and wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] gnt_o,
  output logic          gnt_vld_o
);

  int            idx;
  logic [PW-1:0] idx_w;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      idx_w = PW'(idx);
      if (req_i[idx_w]) begin
        gnt_o     = idx_w;
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between N_REQ
// requesters; one op in flight, IDLE -> EXEC -> RESP.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = ALU_W
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_e           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    gnt_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2:0]       s_q;
  logic [W-1:0]     res_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic             busy_q;

  logic [PW-1:0]    pick;
  logic             pick_vld;
  logic             accept;
  logic [PW-1:0]    ptr_d;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (pick),
    .gnt_vld_o (pick_vld)
  );

  assign accept = (state_q == IDLE) && pick_vld;
  assign ptr_d  = (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;

  assign bus.req_ready = accept ? (ONE << pick) : '0;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_s     = s_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = res_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            a_q     <= bus.req_a[int'(pick)*W +: W];
            b_q     <= bus.req_b[int'(pick)*W +: W];
            s_q     <= bus.req_s[int'(pick)*3 +: 3];
            gnt_q   <= pick;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= bus.alu_r;
          rsp_valid_q <= ONE << gnt_q;
          state_q     <= RESP;
        end
        RESP: begin
          // Only the granted requester's ready ends the response.
          if (bus.rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with two requesters
// and the alv ALU hooked onto the alu_* bundle.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc_cnt;

  alu_share_arbiter_if #(.N_REQ(N), .W(8)) bus ();

  alu_share_arbiter #(.N_REQ(N), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alv u_alu (
    .a (bus.alu_a),
    .b (bus.alu_b),
    .s (bus.alu_s),
    .r (bus.alu_r)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] s;
    logic [7:0] exp;
  } vec_t;

  sb_t sb_q[$];
  int  acc_log[$];
  int  acc_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [7:0] ref_alu(logic [7:0] a, logic [7:0] b,
                                         logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: push on accept, pop on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb_q.push_back('{idx: i,
            data: ref_alu(bus.req_a[i*8 +: 8], bus.req_b[i*8 +: 8],
                          bus.req_s[i*3 +: 3])});
          acc_log.push_back(i);
          acc_cyc.push_back(cyc_cnt);
        end
      end
      if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("rsp_route", 32'(bus.rsp_valid), 32'(2'b01 << e.idx));
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int i, logic [7:0] a, logic [7:0] b,
                        logic [2:0] s);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
    bus.req_s[i*3 +: 3] = s;
  endtask

  task automatic wait_accept(int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (bus.req_ready[i]) ok = 1'b1;
      cyc();
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(int i, output logic [7:0] d);
    bit ok;
    ok = 1'b0;
    d  = '0;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (bus.rsp_valid[i]) begin
        ok = 1'b1;
        d  = bus.rsp_data;
      end
      cyc();
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb_q.size() != 0; n++) cyc();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    vec_t       tbl[8];
    logic [7:0] d;
    logic [7:0] held;
    int         base;

    tbl[0] = '{8'h33, 8'hCC, OP_ADD,  8'hFF};
    tbl[1] = '{8'h33, 8'hCC, OP_SUB,  8'h67};
    tbl[2] = '{8'h33, 8'hCC, OP_AND,  8'h00};
    tbl[3] = '{8'h33, 8'hCC, OP_OR,   8'hFF};
    tbl[4] = '{8'h33, 8'hCC, OP_XOR,  8'hFF};
    tbl[5] = '{8'h33, 8'hCC, OP_NOTA, 8'hCC};
    tbl[6] = '{8'h33, 8'hCC, OP_SHL,  8'h66};
    tbl[7] = '{8'h33, 8'hCC, OP_SHR,  8'h19};

    checks        = 0;
    failures      = 0;
    cyc_cnt       = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_s     = '0;
    bus.rsp_ready = '0;
    repeat (3) cyc();
    rst = 1'b0;

    // Reset state held through idle cycles
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_alu", {8'd0, bus.alu_a, bus.alu_b, 5'd0, bus.alu_s}, 32'd0);
      cyc();
    end

    // Single op from req0 with cycle-exact latency
    set_op(0, 8'h33, 8'hCC, OP_OR);
    bus.req_valid = 2'b01;
    #1;
    chk("t_ready", 32'(bus.req_ready), 32'd1);
    chk("t_busy", 32'(bus.busy), 32'd0);
    cyc();
    bus.req_valid = 2'b00;
    #1;
    chk("t1_alu_a", 32'(bus.alu_a), 32'h33);
    chk("t1_alu_b", 32'(bus.alu_b), 32'hCC);
    chk("t1_alu_s", 32'(bus.alu_s), 32'd3);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    cyc();
    #1;
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t2_rsp_data", 32'(bus.rsp_data), 32'hFF);
    chk("t2_busy", 32'(bus.busy), 32'd1);
    bus.rsp_ready = 2'b01;
    cyc();
    #1;
    chk("t3_busy", 32'(bus.busy), 32'd0);
    chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    drain();

    // Both requesters contending: strict alternation, 3-cycle cadence
    do_reset();
    base = acc_log.size();
    set_op(0, 8'h10, 8'h20, OP_ADD);
    set_op(1, 8'hF0, 8'h0F, OP_SUB);
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    for (int n = 0; n < 40 && acc_log.size() - base < 6; n++) cyc();
    bus.req_valid = 2'b00;
    chk("rr_count", 32'(acc_log.size() - base), 32'd6);
    for (int k = 0; k < 6 && base + k < acc_log.size(); k++)
      chk("rr_order", 32'(acc_log[base+k]), 32'(k % 2));
    for (int k = 1; k < 6 && base + k < acc_cyc.size(); k++)
      chk("rr_cadence", 32'(acc_cyc[base+k] - acc_cyc[base+k-1]), 32'd3);
    drain();

    // Backpressure on req1 while req0 waits
    bus.rsp_ready = 2'b00;
    set_op(1, 8'h55, 8'h0F, OP_AND);
    bus.req_valid = 2'b10;
    wait_accept(1);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b01;
    cyc();
    #1;
    held = bus.rsp_data;
    chk("bp_data", 32'(held), 32'h05);
    for (int k = 0; k < 4; k++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'b10);
      chk("bp_rsp_hold", 32'(bus.rsp_data), 32'(held));
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      cyc();
      #1;
    end
    bus.rsp_ready = 2'b11;
    cyc();
    #1;
    chk("bp_next_grant", 32'(bus.req_ready), 32'b01);
    cyc();
    bus.req_valid = 2'b00;
    drain();

    // Reset during EXEC drops the op and clears ptr
    set_op(0, 8'h10, 8'h20, OP_ADD);
    bus.req_valid = 2'b11;
    wait_accept(1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_alu", {8'd0, bus.alu_a, bus.alu_b, 5'd0, bus.alu_s}, 32'd0);
    chk("mr_ptr_zero", 32'(bus.req_ready), 32'b01);
    wait_accept(0);
    bus.req_valid = 2'b00;
    wait_rsp(0, d);
    chk("mr_rsp_data", 32'(d), 32'h30);
    drain();

    // Opcode sweep through req1
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      set_op(1, tbl[k].a, tbl[k].b, tbl[k].s);
      bus.req_valid = 2'b10;
      wait_accept(1);
      bus.req_valid = 2'b00;
      wait_rsp(1, d);
      chk($sformatf("sweep_op%0d", k), 32'(d), 32'(tbl[k].exp));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
